// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges ID/EX stall requests with MEM flushes and
// drives per-stage stalls, the ID/EX bubble, the redirect PC and a stall stat.
module pipe_ctrl #(
  parameter int CNT_W  = 6,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              ex_mc_start,
  input  logic [CNT_W-1:0]  ex_mc_cycles,
  input  logic              flush_req,
  input  logic [31:0]       flush_target,
  output logic [5:0]        stall,
  output logic              id_ex_bubble,
  output logic              ex_mc_done,
  output logic              flush,
  output logic [31:0]       flush_pc,
  output logic [STAT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    POSTFLUSH
  } state_t;

  localparam logic [5:0] STALL_EX = 6'b001111;
  localparam logic [5:0] STALL_ID = 6'b000111;

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nx;
  logic [STAT_W-1:0]  stat_q;

  always_comb begin
    stall      = '0;
    ex_mc_done = 1'b0;
    flush      = 1'b0;
    flush_pc   = '0;
    state_nx   = state;
    cnt_nx     = cnt;
    if (rst) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else if (flush_req) begin
      flush    = 1'b1;
      flush_pc = flush_target;
      state_nx = POSTFLUSH;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        POSTFLUSH: state_nx = IDLE;
        BUSY: begin
          stall = STALL_EX;
          if (cnt == '0) begin
            ex_mc_done = 1'b1;
            state_nx   = IDLE;
          end else begin
            cnt_nx = cnt - CNT_W'(1);
          end
        end
        default: begin
          if (ex_mc_start) begin
            stall = STALL_EX;
            // zero-length ops are treated as single-cycle
            if (ex_mc_cycles <= CNT_W'(1)) begin
              ex_mc_done = 1'b1;
            end else begin
              cnt_nx   = ex_mc_cycles - CNT_W'(2);
              state_nx = BUSY;
            end
          end else if (stallreq_id) begin
            stall = STALL_ID;
          end
        end
      endcase
    end
  end

  assign id_ex_bubble = stall[2] & ~stall[3];
  assign stall_cnt    = rst ? '0 : stat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      stat_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (|stall && !(&stat_q)) begin
        stat_q <= stat_q + STAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic, checked
// against a remaining-cycles reference model of the sequencer.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id;
  logic        ex_mc_start;
  logic [5:0]  ex_mc_cycles;
  logic        flush_req;
  logic [31:0] flush_target;

  logic [5:0]  stall, stall4;
  logic        bubble, bubble4;
  logic        done, done4;
  logic        flush, flush4;
  logic [31:0] fpc, fpc4;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;

  int nvec = 0;
  int nerr = 0;

  int rem  = 0;
  bit pf   = 0;
  int st16 = 0;
  int st4  = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id),
    .ex_mc_start(ex_mc_start),
    .ex_mc_cycles(ex_mc_cycles),
    .flush_req(flush_req),
    .flush_target(flush_target),
    .stall(stall),
    .id_ex_bubble(bubble),
    .ex_mc_done(done),
    .flush(flush),
    .flush_pc(fpc),
    .stall_cnt(cnt16)
  );

  pipe_ctrl #(.STAT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id),
    .ex_mc_start(ex_mc_start),
    .ex_mc_cycles(ex_mc_cycles),
    .flush_req(flush_req),
    .flush_target(flush_target),
    .stall(stall4),
    .id_ex_bubble(bubble4),
    .ex_mc_done(done4),
    .flush(flush4),
    .flush_pc(fpc4),
    .stall_cnt(cnt4)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h exp %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive, check against model, advance model past the edge.
  task automatic step(input logic r, input logic s,
                      input logic ms, input int mc,
                      input logic fr, input logic [31:0] ft);
    logic [5:0]  e_st;
    logic        e_dn, e_fl;
    logic [31:0] e_pc;
    int          n;
    @(negedge clk);
    rst          = r;
    stallreq_id  = s;
    ex_mc_start  = ms;
    ex_mc_cycles = 6'(mc);
    flush_req    = fr;
    flush_target = ft;
    #1;
    e_st = '0;
    e_dn = 0;
    e_fl = 0;
    e_pc = '0;
    if (r) begin
      rem = 0;
      pf  = 0;
    end else if (fr) begin
      e_fl = 1;
      e_pc = ft;
      rem  = 0;
      pf   = 1;
    end else if (pf) begin
      pf = 0;
    end else if (rem > 0) begin
      e_st = 6'b001111;
      e_dn = (rem == 1);
      rem--;
    end else if (ms) begin
      n    = (mc == 0) ? 1 : mc;
      e_st = 6'b001111;
      e_dn = (n == 1);
      rem  = n - 1;
    end else if (s) begin
      e_st = 6'b000111;
    end
    chk("stall", stall, e_st);
    chk("bubble", bubble, e_st == 6'b000111);
    chk("done", done, e_dn);
    chk("flush", flush, e_fl);
    chk("flush_pc", fpc, e_pc);
    chk("stall_cnt", cnt16, r ? 0 : st16);
    chk("stall_cnt4", cnt4, r ? 0 : st4);
    chk("stall4", {bubble4, done4, flush4, stall4},
        {bubble, done, flush, stall});
    if (r) begin
      st16 = 0;
      st4  = 0;
    end else if (e_st != 0) begin
      st16 = (st16 == 65535) ? st16 : st16 + 1;
      st4  = (st4 == 15) ? st4 : st4 + 1;
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_dut;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset_dut();
    idle(5);

    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    idle(1);
    chk("cnt_after_id2", cnt16, 2);

    step(0, 0, 1, 5, 0, 0);
    idle(5);
    step(0, 0, 1, 0, 0, 0);
    idle(1);
    step(0, 0, 1, 1, 0, 0);
    idle(1);

    step(0, 0, 1, 8, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 3, 0, 0);
    step(0, 0, 0, 0, 1, 32'h0000_0180);
    step(0, 1, 1, 4, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("id_after_pf", stall, 6'b000111);
    idle(2);

    step(0, 1, 1, 3, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    idle(1);

    reset_dut();
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, 0);
    chk("sat4", cnt4, 4'hF);
    idle(1);

    step(0, 0, 1, 10, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    reset_dut();
    idle(12);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 5) == 0,
           ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63)
                                       : $urandom_range(0, 9),
           $urandom_range(0, 11) == 0,
           $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
